io_slave_router: RTL and testbench

- Parametrised successor to the fixed three-way I/O decode and readback mux in the detector-module processing top.
- Routes the 20-bit programming bus to N_SLAVES sub-blocks, each selected by a configurable 4-bit slot code on io_addr[19:16].
- Owns the read transaction: waits for the addressed slave's ack, times out dead slaves, and returns ERR_WORD for timeouts and unmapped slots.
- Exposes its own status/counter register. Sits between the board-level I/O decoder and the stub-tagging / tracklet-search / track-params blocks.

---
 rtl/io_slave_router_pkg.sv | 28 ++
 rtl/io_sat_counter.sv | 25 ++
 rtl/io_slave_router.sv | 185 ++++++++++++++++++
 tb/tb_io_slave_router.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_slave_router_pkg.sv
// Shared slot codes, default error word and timeout, and read FSM states for the I/O slave router.
// No logic of its own; consumed by the router and its sub-blocks.
// No flow control; constants and types only.
package io_slave_router_pkg;

    // Slot codes of the downstream processing blocks and the local status register
    localparam logic [3:0]  SLOT_ST     = 4'h2;   // stub tagging
    localparam logic [3:0]  SLOT_TS     = 4'h4;   // tracklet search
    localparam logic [3:0]  SLOT_TP     = 4'h5;   // track params
    localparam logic [3:0]  SLOT_STATUS = 4'hF;   // router status / counters

    localparam logic [31:0] ERR_WORD_DEF = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_DEF  = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } rd_state_t;

    // Status register layout: last error slot, reserved nibble, unmapped count, timeout count
    function automatic logic [31:0] status_word(input logic [3:0]  err_slot,
                                                input logic [7:0]  um,
                                                input logic [15:0] to);
        return {err_slot, 4'h0, um, to};
    endfunction

endpackage

// File: rtl/io_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
// Count visible one cycle after inc/clr.
// No backpressure; increments beyond all-ones are dropped.
module io_sat_counter #(
    parameter int W = 16
) (
    input  logic         io_clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at all-ones, zero on clr
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/io_slave_router.sv
// Decodes the programming bus onto N slaves by slot code and owns the read transaction (ack wait, timeout, error word).
// Read data one cycle after slave ack; status/unmapped reads one cycle after start; timeout after TIMEOUT_CYCLES in WAIT.
// No backpressure; a stalled slave is cut off by the timeout and one ack is returned per io_sync assertion.
module io_slave_router
    import io_slave_router_pkg::*;
#(
    parameter int                    N_SLAVES       = 3,
    parameter logic [N_SLAVES*4-1:0] SLOT_CODES     = {SLOT_TP, SLOT_TS, SLOT_ST},
    parameter logic [3:0]            STATUS_CODE    = SLOT_STATUS,
    parameter int                    TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter logic [31:0]           ERR_WORD       = ERR_WORD_DEF,
    parameter int                    CNT_W          = 16
) (
    input  logic                    io_clk,
    input  logic                    reset,
    input  logic                    io_sel,
    input  logic                    io_sync,
    input  logic [19:0]             io_addr,
    input  logic                    io_rd_en,
    input  logic                    io_wr_en,
    input  logic [31:0]             io_wr_data,
    output logic [31:0]             io_rd_data,
    output logic                    io_rd_ack,
    output logic [N_SLAVES-1:0]     slv_sel,
    output logic [15:0]             slv_addr,
    input  logic [32*N_SLAVES-1:0]  slv_rd_data,
    input  logic [N_SLAVES-1:0]     slv_rd_ack,
    output logic                    busy
);

    localparam int            IW         = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int            TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    rd_state_t         state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [IW-1:0]     idx, idx_nxt, hit_idx;
    logic              hit, is_status, start, sync_q, clr_req;
    logic              ack_nxt;
    logic [31:0]       data_nxt;
    logic              to_inc, um_inc, err_ld;
    logic [3:0]        slot, err_nxt, last_err_slot;
    logic [CNT_W-1:0]  to_cnt, um_cnt;
    logic              unused_wr_data;

    assign slot      = io_addr[19:16];
    assign slv_addr  = io_addr[15:0];
    assign is_status = (slot == STATUS_CODE);
    assign start     = io_sel & io_sync & io_rd_en;
    // Counter clear is a pure write (read wins when both enables are high), taken once on the io_sync rising edge
    assign clr_req   = io_sel & io_sync & ~sync_q & io_wr_en & ~io_rd_en & is_status & io_wr_data[0];
    assign busy      = (state == ST_WAIT);
    // Only bit 0 of the write data means anything to the router itself
    assign unused_wr_data = ^io_wr_data[31:1];

    // Slot-code decode to one-hot slave select and the matching slave index
    always_comb begin
        slv_sel = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (slot == SLOT_CODES[4*i +: 4]) begin
                slv_sel[i] = io_sel;
                hit        = 1'b1;
                hit_idx    = IW'(i);
            end
        end
    end

    // Read FSM next state and the read-data / counter update requests
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idx_nxt   = idx;
        ack_nxt   = 1'b0;
        data_nxt  = io_rd_data;
        to_inc    = 1'b0;
        um_inc    = 1'b0;
        err_ld    = 1'b0;
        err_nxt   = last_err_slot;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_status) begin
                        ack_nxt   = 1'b1;
                        data_nxt  = status_word(last_err_slot, 8'(um_cnt), 16'(to_cnt));
                        state_nxt = ST_HOLD;
                    end else if (hit) begin
                        idx_nxt   = hit_idx;
                        timer_nxt = '0;
                        state_nxt = ST_WAIT;
                    end else begin
                        ack_nxt   = 1'b1;
                        data_nxt  = ERR_WORD;
                        um_inc    = 1'b1;
                        err_ld    = 1'b1;
                        err_nxt   = slot;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                // Abort beats ack, ack beats timeout
                if (!io_sync) begin
                    state_nxt = ST_IDLE;
                end else if (slv_rd_ack[idx]) begin
                    ack_nxt   = 1'b1;
                    data_nxt  = slv_rd_data[32*idx +: 32];
                    state_nxt = ST_HOLD;
                end else if (timer == TIMER_LAST) begin
                    ack_nxt   = 1'b1;
                    data_nxt  = ERR_WORD;
                    to_inc    = 1'b1;
                    err_ld    = 1'b1;
                    err_nxt   = SLOT_CODES[4*idx +: 4];
                    state_nxt = ST_HOLD;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!io_sync) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, wait timer, latched slave index and registered read response
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            idx        <= '0;
            io_rd_ack  <= 1'b0;
            io_rd_data <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            idx       <= idx_nxt;
            io_rd_ack <= ack_nxt;
            if (ack_nxt) begin
                io_rd_data <= data_nxt;
            end
        end
    end

    // Previous io_sync for rising-edge detection of the counter clear
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= io_sync;
        end
    end

    // Slot code of the most recent timeout or unmapped access
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            last_err_slot <= '0;
        end else if (clr_req) begin
            last_err_slot <= '0;
        end else if (err_ld) begin
            last_err_slot <= err_nxt;
        end
    end

    io_sat_counter #(.W(CNT_W)) u_to_cnt (
        .io_clk (io_clk),
        .reset  (reset),
        .inc    (to_inc),
        .clr    (clr_req),
        .cnt    (to_cnt)
    );

    io_sat_counter #(.W(CNT_W)) u_um_cnt (
        .io_clk (io_clk),
        .reset  (reset),
        .inc    (um_inc),
        .clr    (clr_req),
        .cnt    (um_cnt)
    );

endmodule

// File: tb/tb_io_slave_router.sv
module tb_io_slave_router;

    localparam int          N   = 3;
    localparam int          TO  = 16;
    localparam int          CW  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic            io_clk = 1'b0;
    logic            reset;
    logic            io_sel, io_sync, io_rd_en, io_wr_en;
    logic [19:0]     io_addr;
    logic [31:0]     io_wr_data, io_rd_data;
    logic            io_rd_ack;
    logic [N-1:0]    slv_sel;
    logic [15:0]     slv_addr;
    logic [32*N-1:0] slv_rd_data;
    logic [N-1:0]    slv_rd_ack;
    logic            busy;

    always #5 io_clk = ~io_clk;

    io_slave_router #(
        .N_SLAVES       (N),
        .SLOT_CODES     (12'h542),
        .STATUS_CODE    (4'hF),
        .TIMEOUT_CYCLES (TO),
        .ERR_WORD       (ERR),
        .CNT_W          (CW)
    ) dut (
        .io_clk      (io_clk),
        .reset       (reset),
        .io_sel      (io_sel),
        .io_sync     (io_sync),
        .io_addr     (io_addr),
        .io_rd_en    (io_rd_en),
        .io_wr_en    (io_wr_en),
        .io_wr_data  (io_wr_data),
        .io_rd_data  (io_rd_data),
        .io_rd_ack   (io_rd_ack),
        .slv_sel     (slv_sel),
        .slv_addr    (slv_addr),
        .slv_rd_data (slv_rd_data),
        .slv_rd_ack  (slv_rd_ack),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: abstract counters, last error slot and last returned word
    int          m_to, m_um;
    logic [3:0]  m_last;
    logic [31:0] m_rd;
    int          slot_codes [N] = '{2, 4, 5};
    logic [3:0]  code_tab [8]   = '{4'h2, 4'h4, 4'h5, 4'h7, 4'h0, 4'hF, 4'h1, 4'h9};
    localparam int CNT_MAX = (1 << CW) - 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    function automatic int slave_of(input logic [3:0] code);
        int r = -1;
        for (int i = 0; i < N; i++) if (slot_codes[i] == int'(code)) r = i;
        return r;
    endfunction

    function automatic logic [31:0] status_exp();
        logic [7:0]  um8  = 8'(m_um);
        logic [15:0] to16 = 16'(m_to);
        return {m_last, 4'h0, um8, to16};
    endfunction

    task automatic model_reset();
        m_to = 0; m_um = 0; m_last = 4'h0; m_rd = 32'h0;
    endtask

    task automatic idle_inputs();
        io_sel = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0; io_wr_en = 1'b0;
        slv_rd_ack = '0;
    endtask

    // One read; delay = cycle after start on which the addressed slave acks (0 = never)
    task automatic do_read(input logic [3:0] code, input int delay, input logic [31:0] sdata,
                           input int hold, input logic spur, output logic [31:0] got);
        int          s = slave_of(code);
        int          exp_lat, lat = -1, busy_cnt = 0, extra_acks = 0;
        logic [31:0] exp_data;
        logic [N-1:0] exp_sel = '0;
        logic [15:0] low = 16'($urandom);
        got = 32'hx;
        if (code == 4'hF) begin
            exp_lat = 1; exp_data = status_exp();
        end else if (s < 0) begin
            exp_lat = 1; exp_data = ERR;
            if (m_um < CNT_MAX) m_um++;
            m_last = code;
        end else if (delay >= 1 && delay <= TO) begin
            exp_lat = delay + 1; exp_data = sdata;
        end else begin
            exp_lat = TO + 1; exp_data = ERR;
            if (m_to < CNT_MAX) m_to++;
            m_last = code;
        end
        if (s >= 0) exp_sel[s] = 1'b1;
        for (int i = 0; i < N; i++) slv_rd_data[32*i +: 32] = $urandom;
        if (s >= 0) slv_rd_data[32*s +: 32] = sdata;
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_wr_en = 1'($urandom);
        io_wr_data = $urandom; io_addr = {code, low};
        #1;
        check("slv_sel", 32'(slv_sel), 32'(exp_sel));
        check("slv_addr", 32'(slv_addr), 32'(low));
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (io_rd_ack) begin lat = c; got = io_rd_data; break; end
            if (busy) busy_cnt++;
            slv_rd_ack = '0;
            if (s >= 0 && c == delay) slv_rd_ack[s] = 1'b1;
            if (spur && s >= 0 && c == 2) slv_rd_ack[(s + 1) % N] = 1'b1;
        end
        slv_rd_ack = '0;
        check("ack_latency", 32'(lat), 32'(exp_lat));
        check("rd_data", got, exp_data);
        check("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        m_rd = exp_data;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (io_rd_ack) extra_acks++;
        end
        if (hold > 0) begin
            check("hold_acks", 32'(extra_acks), 32'd0);
            check("hold_data", io_rd_data, m_rd);
        end
        idle_inputs();
        tick();
        check("idle_after_rd", {30'd0, busy, io_rd_ack}, 32'd0);
    endtask

    // Write held for three cycles; only status writes with bit0 set clear the counters
    task automatic do_write(input logic [3:0] code, input logic [31:0] data);
        int bad = 0;
        io_sel = 1'b1; io_sync = 1'b1; io_wr_en = 1'b1; io_rd_en = 1'b0;
        io_addr = {code, 16'($urandom)}; io_wr_data = data;
        if (code == 4'hF && data[0]) begin m_to = 0; m_um = 0; m_last = 4'h0; end
        repeat (3) begin
            tick();
            if (busy || io_rd_ack) bad++;
        end
        check("write_no_txn", 32'(bad), 32'd0);
        idle_inputs();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          acks;
        reset = 1'b1;
        idle_inputs();
        io_addr = '0; io_wr_data = '0; slv_rd_data = '0;
        model_reset();
        repeat (3) @(posedge io_clk);
        #1;
        check("reset_rd_data", io_rd_data, 32'h0);
        check("reset_ack_busy", {30'd0, busy, io_rd_ack}, 32'd0);
        check("reset_sel", 32'(slv_sel), 32'd0);
        reset = 1'b0;
        tick();

        // Slot 4, slave1 acks 5 cycles after start
        do_read(4'h4, 5, 32'h1234_5678, 0, 1'b0, got);
        check("slot4_data", got, 32'h1234_5678);
        do_read(4'hF, 0, 32'h0, 0, 1'b0, got);
        check("status_clean", got, 32'h0);

        // Slot 5 never acks -> timeout, then status
        do_read(4'h5, 0, 32'h0, 0, 1'b0, got);
        check("timeout_word", got, ERR);
        do_read(4'hF, 0, 32'h0, 0, 1'b0, got);
        check("status_after_to", got, 32'h5000_0001);

        // Unmapped slot 7, status, non-clearing write, clearing write
        do_write(4'hF, 32'h1);
        do_read(4'h7, 0, 32'h0, 0, 1'b0, got);
        check("unmapped_word", got, ERR);
        do_read(4'hF, 0, 32'h0, 0, 1'b0, got);
        check("status_after_um", got, 32'h7001_0000);
        do_write(4'hF, 32'h2);
        do_read(4'hF, 0, 32'h0, 0, 1'b0, got);
        check("status_noclear", got, 32'h7001_0000);
        do_write(4'hF, 32'h1);
        do_read(4'hF, 0, 32'h0, 0, 1'b0, got);
        check("status_cleared", got, 32'h0);

        // Slave ack on the timeout cycle wins; spurious ack from slave1 ignored
        do_read(4'h2, TO, 32'hCAFE_0002, 0, 1'b1, got);
        check("ack_vs_timeout", got, 32'hCAFE_0002);
        do_read(4'hF, 0, 32'h0, 0, 1'b0, got);
        check("status_no_to", got, 32'h0);

        // Slave write creates no transaction
        do_write(4'h4, 32'hFFFF_FFFF);

        // io_sync dropped in WAIT at cycle 3
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_addr = 20'h5_0010;
        repeat (3) tick();
        check("abort_busy", 32'(busy), 32'd1);
        idle_inputs();
        acks = 0;
        repeat (4) begin tick(); if (io_rd_ack) acks++; end
        check("abort_acks", 32'(acks), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_data", io_rd_data, m_rd);

        // Reset asserted mid-WAIT
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_addr = 20'h4_0020;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_mid_data", io_rd_data, 32'h0);
        check("rst_mid_ack_busy", {30'd0, busy, io_rd_ack}, 32'd0);
        idle_inputs();
        tick();
        reset = 1'b0;
        acks = 0;
        repeat (3) begin tick(); if (io_rd_ack || busy) acks++; end
        check("rst_mid_quiet", 32'(acks), 32'd0);

        // Long io_sync hold after ack gives a single pulse
        do_read(4'h4, 2, 32'hA5A5_0004, 10, 1'b0, got);

        // Timeout counter saturates at 15
        for (int k = 0; k < 20; k++) do_read(4'h5, 0, 32'h0, 0, 1'b0, got);
        do_read(4'hF, 0, 32'h0, 0, 1'b0, got);
        check("to_saturated", got, 32'h5000_000F);

        // Randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            logic [3:0] code = code_tab[$urandom_range(0, 7)];
            int         dly  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
            if (k % 7 == 6) do_write(($urandom_range(0, 1) == 0) ? 4'hF : 4'h2, $urandom);
            do_read(code, dly, $urandom, int'($urandom_range(0, 3)), 1'($urandom), got);
        end
        do_read(4'hF, 0, 32'h0, 0, 1'b0, got);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
